// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues imem reads at the current PC under a credit
// limit, tags in-flight reads with their PC, and queues returned words for decode.
module instr_fetch_unit #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        pc_write,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] occupancy_q,   occupancy_d;
  logic [CW-1:0] discard_q,     discard_d;
  logic [AW-1:0] tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
  logic [AW-1:0] q_wp_q,   q_wp_d,   q_rp_q,   q_rp_d;
  logic [31:0]   tag_q [DEPTH];
  fetch_ent_t    ent_q [DEPTH];

  logic [CW:0] inuse;
  logic        credit, grant, resp, drop_rsp, keep, pop;

  // Credit counts reads in flight plus buffered words, so a returning read
  // always finds a free queue slot.
  assign inuse     = {1'b0, outstanding_q} + {1'b0, occupancy_q};
  assign credit    = inuse < (CW+1)'(DEPTH);
  assign imem_req  = reset & ~flush & credit;
  assign imem_addr = pc;
  assign grant     = imem_req & imem_gnt;
  assign pc_write  = reset & (flush | grant);

  assign id_valid  = (occupancy_q != '0);
  assign id_pc     = ent_q[q_rp_q].pc;
  assign id_instr  = ent_q[q_rp_q].instr;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign resp     = imem_rvalid & (outstanding_q != '0);
  assign drop_rsp = resp & (flush | (discard_q != '0));
  assign keep     = resp & ~drop_rsp;
  assign pop      = id_valid & id_ready & ~flush;

  always_comb begin
    outstanding_d = outstanding_q;
    unique case ({grant, resp})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase

    occupancy_d = occupancy_q;
    if (flush) occupancy_d = '0;
    else begin
      unique case ({keep, pop})
        2'b10:   occupancy_d = occupancy_q + CW'(1);
        2'b01:   occupancy_d = occupancy_q - CW'(1);
        default: occupancy_d = occupancy_q;
      endcase
    end

    // No grant can coincide with flush, so the reads left in flight after the
    // edge are exactly the ones to throw away.
    discard_d = discard_q;
    if (flush) discard_d = resp ? outstanding_q - CW'(1) : outstanding_q;
    else if (resp && discard_q != '0) discard_d = discard_q - CW'(1);

    tag_wp_d = grant ? tag_wp_q + AW'(1) : tag_wp_q;
    tag_rp_d = resp  ? tag_rp_q + AW'(1) : tag_rp_q;
    q_wp_d   = keep  ? q_wp_q + AW'(1)   : q_wp_q;
    q_rp_d   = flush ? q_wp_q : (pop ? q_rp_q + AW'(1) : q_rp_q);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      outstanding_q <= '0;
      occupancy_q   <= '0;
      discard_q     <= '0;
      tag_wp_q      <= '0;
      tag_rp_q      <= '0;
      q_wp_q        <= '0;
      q_rp_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
        ent_q[i] <= '0;
      end
    end else begin
      outstanding_q <= outstanding_d;
      occupancy_q   <= occupancy_d;
      discard_q     <= discard_d;
      tag_wp_q      <= tag_wp_d;
      tag_rp_q      <= tag_rp_d;
      q_wp_q        <= q_wp_d;
      q_rp_q        <= q_rp_d;
      if (grant) tag_q[tag_wp_q] <= pc;
      if (keep)  ent_q[q_wp_q]   <= '{pc: tag_q[tag_rp_q], instr: imem_rdata};
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: program counter + in-order memory environment,
// a queue-level reference model, directed scenarios and a randomized run.
module tb_instr_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, imem_gnt, imem_rvalid, id_ready;
  logic [31:0] pc, imem_rdata;
  logic        pc_write, imem_req, id_valid;
  logic [31:0] imem_addr, id_instr, id_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .pc(pc), .flush(flush),
    .pc_write(pc_write), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
  );

  typedef struct { logic [31:0] pc; int due; } mreq_t;
  typedef struct { logic [31:0] pc; bit stale; } infl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  mreq_t mem_q[$];
  infl_t m_infl[$];
  ent_t  m_buf[$];
  bit    m_zero;

  int          cyc, n_cmp, n_bad;
  logic [31:0] pc_nxt, k_tgt;
  bit          k_rst, k_flush;
  int          k_lat, rdy_pct, gnt_pct;

  function automatic logic [31:0] f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then wait to the sample point.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    pc       = pc_nxt;
    reset    = k_rst;
    flush    = k_flush;
    id_ready = ($urandom_range(99) < rdy_pct);
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = f(mem_q[0].pc);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #2;
  endtask

  // Reference model: compare then advance, once per cycle on the falling edge.
  always @(negedge clk) begin
    bit   exp_req, exp_pcw, exp_valid, pop, grant;
    int   lat;
    infl_t e;
    exp_req   = reset && !flush && (m_infl.size() + m_buf.size() < DEPTH);
    exp_pcw   = reset && (flush || (exp_req && imem_gnt));
    exp_valid = (m_buf.size() != 0);
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    check("pc_write", {31'b0, pc_write}, {31'b0, exp_pcw});
    if (exp_req) check("imem_addr", imem_addr, pc);
    check("id_valid", {31'b0, id_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      check("id_pc", id_pc, m_buf[0].pc);
      check("id_instr", id_instr, m_buf[0].instr);
    end else if (m_zero) begin
      check("id_pc_rst", id_pc, 32'h0);
      check("id_instr_rst", id_instr, 32'h0);
    end
    check("credit_bound", {31'b0, (m_infl.size() + m_buf.size()) <= DEPTH}, 32'h1);

    grant = reset && imem_req && imem_gnt;
    if (!reset) begin
      mem_q.delete();
      m_infl.delete();
      m_buf.delete();
      m_zero = 1'b1;
      pc_nxt = 32'h0;
    end else begin
      assert (!(imem_rvalid && m_infl.size() == 0))
        else $error("imem_rvalid with nothing outstanding");
      pop = exp_valid && id_ready && !flush;
      if (pop) void'(m_buf.pop_front());
      if (imem_rvalid && m_infl.size() > 0) begin
        e = m_infl.pop_front();
        void'(mem_q.pop_front());
        if (!e.stale && !flush) begin
          m_buf.push_back('{e.pc, f(e.pc)});
          m_zero = 1'b0;
        end
      end
      if (grant) begin
        lat = (k_lat == 0) ? int'($urandom_range(4, 1)) : k_lat;
        m_infl.push_back('{pc, 1'b0});
        mem_q.push_back('{pc, cyc + lat});
      end
      if (flush) begin
        m_buf.delete();
        foreach (m_infl[i]) m_infl[i].stale = 1'b1;
      end
      pc_nxt = pc_write ? (flush ? k_tgt : pc + 32'd1) : pc;
    end
  end

  task automatic do_reset();
    k_rst = 1'b0; k_flush = 1'b0;
    repeat (2) tick();
    k_rst = 1'b1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    id_ready = 1'b0; pc = 32'h0; imem_rdata = 32'h0;
    pc_nxt = 32'h0; k_tgt = 32'h0; k_rst = 1'b0; k_flush = 1'b0;
    k_lat = 1; rdy_pct = 100; gnt_pct = 100; m_zero = 1'b1;
    cyc = 0; n_cmp = 0; n_bad = 0;

    // Reset state, then straight-line fetch at L=1.
    repeat (3) tick();
    check("rst_id_valid", {31'b0, id_valid}, 32'h0);
    check("rst_imem_req", {31'b0, imem_req}, 32'h0);
    check("rst_pc_write", {31'b0, pc_write}, 32'h0);
    check("rst_id_pc", id_pc, 32'h0);
    k_rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("line_pc_write", {31'b0, pc_write}, 32'h1);
      if (k >= 3) begin
        check("line_id_valid", {31'b0, id_valid}, 32'h1);
        check("line_id_pc", id_pc, 32'(k - 3));
        check("line_id_instr", id_instr, f(32'(k - 3)));
      end
    end

    // Decode stall fills the credit, then drains in order.
    do_reset();
    rdy_pct = 0;
    repeat (8) tick();
    check("stall_req", {31'b0, imem_req}, 32'h0);
    check("stall_pc_write", {31'b0, pc_write}, 32'h0);
    check("stall_id_valid", {31'b0, id_valid}, 32'h1);
    check("stall_id_pc", id_pc, 32'h0);
    rdy_pct = 100;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("drain_id_pc", id_pc, 32'(j));
    end

    // Flush with two reads in flight at L=3.
    k_lat = 3;
    do_reset();
    repeat (2) tick();
    k_flush = 1'b1; k_tgt = 32'h40;
    tick();
    check("flush_req", {31'b0, imem_req}, 32'h0);
    check("flush_pc_write", {31'b0, pc_write}, 32'h1);
    k_flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flush_gap_valid", {31'b0, id_valid}, 32'h0);
    end
    tick();
    check("redir_valid", {31'b0, id_valid}, 32'h1);
    check("redir_id_pc", id_pc, 32'h40);

    // Flush coinciding with a response and a decode pop at L=2.
    k_lat = 2;
    do_reset();
    repeat (3) tick();
    k_flush = 1'b1; k_tgt = 32'h80;
    tick();
    check("fr_valid_at_flush", {31'b0, id_valid}, 32'h1);
    k_flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fr_gap_valid", {31'b0, id_valid}, 32'h0);
    end
    tick();
    check("fr_id_pc", id_pc, 32'h80);

    // Randomized latency, grant backpressure, decode stalls and redirects.
    k_lat = 0; gnt_pct = 75; rdy_pct = 70;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      k_flush = ($urandom_range(29) == 0);
      k_tgt   = $urandom;
      tick();
    end
    k_flush = 1'b0;

    // Reset mid-stream with reads in flight and words buffered.
    k_lat = 4; gnt_pct = 100; rdy_pct = 0;
    repeat (6) tick();
    k_rst = 1'b0;
    tick();
    check("mid_rst_req", {31'b0, imem_req}, 32'h0);
    check("mid_rst_pcw", {31'b0, pc_write}, 32'h0);
    tick();
    check("mid_rst_valid", {31'b0, id_valid}, 32'h0);
    check("mid_rst_id_pc", id_pc, 32'h0);
    check("mid_rst_id_instr", id_instr, 32'h0);
    k_rst = 1'b1; rdy_pct = 100; k_lat = 1;
    tick();
    check("restart_req", {31'b0, imem_req}, 32'h1);
    check("restart_addr", imem_addr, 32'h0);
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
